// File: rtl/mc10_bus_ctrl_pkg.sv
// mc10_pkg - shared types and address map for the MC-10 bus controller.
//   region_t : decoded bus region of the current CPU address
//   state_t  : bus-cycle state (RUN = normal phase stepping, WAIT = stretched
//              expansion read)
//   *_BASE / *_LIM : address map boundaries (LIM values are exclusive)
//   ram_aw() : RAM address width for a given internal RAM size in KB
package mc10_pkg;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_ROM,
    REG_RAM,
    REG_IO,
    REG_EXP
  } region_t;

  typedef enum logic {
    RUN,
    WAIT
  } state_t;

  localparam logic [15:0] RAM_BASE    = 16'h4000;
  localparam logic [15:0] RAM_LIM_4K  = 16'h5000;
  localparam logic [15:0] RAM_LIM_20K = 16'h9000;
  localparam logic [15:0] IO_BASE     = 16'h8000;
  localparam logic [15:0] ROM_BASE    = 16'hE000;

  // Value returned for unmapped reads and timed-out expansion reads.
  localparam logic [7:0] OPEN_BUS = 8'hFF;

  // 4K maps $4000-$4FFF (12 bits); the 16K pack extends to $8FFF (15 bits).
  function automatic int ram_aw(input int ram_kb);
    return (ram_kb == 20) ? 15 : 12;
  endfunction

endpackage

// File: rtl/mc10_bus_ctrl_if.sv
// mc10_bus_ctrl_if - bus signals between the MC-10 bus controller and the
// 6803 core / ROM / RAM / keyboard / expansion connector.
//   CPU side   : cpu_addr, cpu_rw, cpu_dout -> ; <- cpu_ce, cpu_din
//   memories   : rom_dout, ram_dout -> ; <- rom_cs, ram_we, ram_addr
//   keyboard   : kbd_rows ->
//   expansion  : exp_sel, exp_ready, exp_dout -> ; <- exp_cs
//   video/sound: <- vdg_mode, audio
// modport master : the controller's view
// modport slave  : the view of everything around the controller
interface mc10_bus_ctrl_if #(
  parameter int RAM_AW = 12
);
  logic [15:0]       cpu_addr;
  logic              cpu_rw;
  logic [7:0]        cpu_dout;
  logic              exp_sel;
  logic              exp_ready;
  logic [7:0]        rom_dout;
  logic [7:0]        ram_dout;
  logic [5:0]        kbd_rows;
  logic [7:0]        exp_dout;
  logic              cpu_ce;
  logic [7:0]        cpu_din;
  logic              rom_cs;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic              exp_cs;
  logic [5:0]        vdg_mode;
  logic              audio;

  modport master (
    input  cpu_addr, cpu_rw, cpu_dout, exp_sel, exp_ready,
           rom_dout, ram_dout, kbd_rows, exp_dout,
    output cpu_ce, cpu_din, rom_cs, ram_we, ram_addr, exp_cs,
           vdg_mode, audio
  );

  modport slave (
    output cpu_addr, cpu_rw, cpu_dout, exp_sel, exp_ready,
           rom_dout, ram_dout, kbd_rows, exp_dout,
    input  cpu_ce, cpu_din, rom_cs, ram_we, ram_addr, exp_cs,
           vdg_mode, audio
  );
endinterface

// File: rtl/mc10_bus_ctrl_addr_decode.sv
// mc10_addr_decode - combinational region decode of the 6803 address.
//   i_addr    in  16  CPU address
//   i_exp_sel in  1   expansion owns the low map; internal ROM/RAM deselected
//   o_region  out     decoded region
// Map: EXP $0000-$3FFF, RAM $4000-$4FFF (4K) or $4000-$8FFF (20K),
//      IO $8000-$BFFF, ROM $E000-$FFFF, everything else unmapped.
module mc10_addr_decode
  import mc10_pkg::*;
#(
  parameter int RAM_KB = 4
) (
  input  logic [15:0] i_addr,
  input  logic        i_exp_sel,
  output region_t     o_region
);

  localparam logic [15:0] RAM_LIM = (RAM_KB == 20) ? RAM_LIM_20K : RAM_LIM_4K;

  logic w_exp;
  logic w_ram;
  logic w_io;
  logic w_rom;

  assign w_exp = (i_addr < RAM_BASE);
  assign w_ram = !i_exp_sel && (i_addr >= RAM_BASE) && (i_addr < RAM_LIM);
  assign w_io  = (i_addr[15:14] == IO_BASE[15:14]);
  assign w_rom = !i_exp_sel && (i_addr >= ROM_BASE);

  // With the 16K pack, $8000-$8FFF is RAM even though it lies in the IO block.
  always_comb begin
    o_region = REG_NONE;
    if (w_exp)      o_region = REG_EXP;
    else if (w_ram) o_region = REG_RAM;
    else if (w_io)  o_region = REG_IO;
    else if (w_rom) o_region = REG_ROM;
  end

endmodule

// File: rtl/mc10_bus_ctrl.sv
// mc10_bus_ctrl - MC-10 system bus controller.
// Derives the one-clk_4 CPU clock enable from clk_4, decodes the CPU address,
// owns the VDG-mode/sound latch and the registered read-data mux, and
// stretches expansion reads with wait states.
//   clk_4  in  1  system clock
//   RESET  in  1  synchronous, active-high reset
//   bus    master modport of mc10_bus_ctrl_if (CPU, memories, keyboard,
//          expansion, video/sound signals)
//
// state | meaning
// RUN   | phase steps 0..DIV-1; access at DIV-2, cpu_ce at DIV-1
// WAIT  | expansion read pending; phase frozen at DIV-2, cpu_ce held low
module mc10_bus_ctrl
  import mc10_pkg::*;
#(
  parameter int DIV         = 4,
  parameter int RAM_KB      = 4,
  parameter int EXP_TIMEOUT = 15
) (
  input  logic           clk_4,
  input  logic           RESET,
  mc10_bus_ctrl_if.master bus
);

  localparam int RAM_AW = ram_aw(RAM_KB);
  localparam int PW     = $clog2(DIV);
  localparam int WW     = $clog2(EXP_TIMEOUT + 1);

  localparam logic [PW-1:0]     PH_ACC  = PW'(DIV - 2);
  localparam logic [PW-1:0]     PH_LAST = PW'(DIV - 1);
  localparam logic [WW-1:0]     W_LAST  = WW'(EXP_TIMEOUT - 1);
  localparam logic [RAM_AW-1:0] RAM_OFS = RAM_BASE[RAM_AW-1:0];

  state_t            r_state;
  state_t            w_state_nx;
  logic [PW-1:0]     r_phase;
  logic [PW-1:0]     w_phase_nx;
  logic [WW-1:0]     r_wcnt;
  logic [WW-1:0]     w_wcnt_nx;
  logic [7:0]        r_din;
  logic [7:0]        w_din_nx;
  logic [5:0]        r_vdg;
  logic [5:0]        w_vdg_nx;
  logic              r_live;
  logic              w_ram_we;
  logic              w_cpu_ce;
  logic [7:0]        w_rd_data;
  logic [RAM_AW-1:0] w_ram_addr;
  region_t           w_region;

  mc10_addr_decode #(
    .RAM_KB (RAM_KB)
  ) u_decode (
    .i_addr    (bus.cpu_addr),
    .i_exp_sel (bus.exp_sel),
    .o_region  (w_region)
  );

  always_comb begin
    w_rd_data = OPEN_BUS;
    case (w_region)
      REG_ROM: w_rd_data = bus.rom_dout;
      REG_RAM: w_rd_data = bus.ram_dout;
      REG_IO:  w_rd_data = {2'b11, bus.kbd_rows};
      REG_EXP: w_rd_data = bus.exp_dout;
      default: w_rd_data = OPEN_BUS;
    endcase
  end

  // Offset from $4000; the low bits of the base are zero for the 4K map, and
  // modulo-2^15 subtraction gives the right offset for the 20K map.
  assign w_ram_addr = bus.cpu_addr[RAM_AW-1:0] - RAM_OFS;

  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    w_wcnt_nx  = r_wcnt;
    w_din_nx   = r_din;
    w_vdg_nx   = r_vdg;
    w_ram_we   = 1'b0;
    w_cpu_ce   = 1'b0;
    case (r_state)
      RUN: begin
        w_cpu_ce   = (r_phase == PH_LAST);
        w_phase_nx = (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
        if (r_phase == PH_ACC) begin
          if (bus.cpu_rw) begin
            if (w_region == REG_EXP && !bus.exp_ready) begin
              w_state_nx = WAIT;
              w_phase_nx = r_phase;
              w_wcnt_nx  = '0;
            end else begin
              w_din_nx = w_rd_data;
            end
          end else begin
            w_ram_we = (w_region == REG_RAM);
            if (w_region == REG_IO) w_vdg_nx = bus.cpu_dout[7:2];
          end
        end
      end
      WAIT: begin
        // Resuming at PH_LAST makes cpu_ce fire on the following clk_4.
        if (bus.exp_ready) begin
          w_state_nx = RUN;
          w_phase_nx = PH_LAST;
          w_din_nx   = bus.exp_dout;
        end else if (r_wcnt == W_LAST) begin
          w_state_nx = RUN;
          w_phase_nx = PH_LAST;
          w_din_nx   = OPEN_BUS;
        end else begin
          w_wcnt_nx = r_wcnt + 1'b1;
        end
      end
      default: w_state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk_4) begin
    if (RESET) begin
      r_state <= RUN;
      r_phase <= '0;
      r_wcnt  <= '0;
      r_din   <= OPEN_BUS;
      r_vdg   <= '0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_phase <= w_phase_nx;
      r_wcnt  <= w_wcnt_nx;
      r_din   <= w_din_nx;
      r_vdg   <= w_vdg_nx;
      r_live  <= 1'b1;
    end
  end

  // Chip selects are held off for the first clk_4 after reset so that a
  // stale address left over from an aborted cycle does not select anything.
  assign bus.cpu_ce   = w_cpu_ce;
  assign bus.cpu_din  = r_din;
  assign bus.rom_cs   = r_live && (w_region == REG_ROM);
  assign bus.exp_cs   = r_live && (w_region == REG_EXP);
  assign bus.ram_we   = w_ram_we;
  assign bus.ram_addr = (r_live && w_region == REG_RAM) ? w_ram_addr : '0;
  assign bus.vdg_mode = r_vdg;
  assign bus.audio    = r_vdg[5];

endmodule
